taint_event_scanner: RTL and testbench
======================================

# taint_event_scanner

Simulation-side monitor that round-robin polls the `taint_sum` outputs of up to `N_SRC` taint-tracked registers and memories, detects changes in each sum, and emits timestamped change events through a valid/ready FIFO to the testbench logger. It also latches the first cycle at which any source becomes tainted. It sits beside the instrumented SoC top, one instance per monitored subsystem, and is the sole consumer of the per-cell taint summaries.

## Interface
- `N_SRC`, 8: number of monitored sources (≥2).
- `SUM_W`, 16: width of each source's taint sum; narrower sums are zero-extended at the instance.
- `TS_W`, 32: timestamp width.
- `DEPTH`, 8: event FIFO depth, power of two, ≥2.
- `IDX_W`, `$clog2(N_SRC)`: derived; not overridden.

Ports:
- `pos_clk` in 1: clock, rising edge.
- `pos_arst` in 1: reset, asynchronous, active-high. Clock is `pos_clk`.
- `enable` in 1: scan and timestamp advance when high.
- `clear` in 1: synchronous full clear; priority over all other activity.
- `src_sum` in N_SRC*SUM_W: source i in bits `[i*SUM_W +: SUM_W]`.
- `ev_valid` out 1: event available.
- `ev_ready` in 1: consumer accepts.
- `ev_src` out IDX_W: source index of the event.
- `ev_sum` out SUM_W: new sum value.
- `ev_prev` out SUM_W: previous recorded sum.
- `ev_time` out TS_W: timestamp of the sampling cycle.
- `drop_cnt` out 16: saturating count of events lost to a full FIFO.
- `any_taint` out 1: OR of all recorded sums.
- `first_valid` out 1: sticky; some source has been seen nonzero.
- `first_src` out IDX_W, `first_time` out TS_W: source and timestamp of the first nonzero observation.

## Operation
- State: scan pointer `ptr`, timestamp `ts`, recorded sums `last[N_SRC]`, FIFO, `drop_cnt`, first-taint latch.
- FSM states:
  - IDLE: entered from reset or `clear`; moves to SCAN on `enable`.
  - SCAN: moves back to IDLE when `enable` is low.
  - No scanning activity occurs in IDLE.
- Each SCAN cycle:
  - Sample `s = src_sum[ptr]`.
  - If `s != last[ptr]`: form event {ptr, s, last[ptr], ts}, push it to the FIFO, and set `last[ptr] <= s`.
  - `ptr` wraps from N_SRC-1 to 0.
  - `ts` increments and wraps modulo 2^TS_W.
- FIFO full on push:
  - The event is dropped and `drop_cnt` increments, saturating at 0xFFFF.
  - `last[ptr]` is still updated, so the same change is not reported again.
- Push while full with a simultaneous pop (`ev_valid & ev_ready`): the push succeeds and nothing is dropped.
- First-taint latch: the first SCAN cycle with `s != 0` sets `first_valid=1` and records `first_src=ptr` and `first_time=ts`. The latch then holds until reset or `clear`.
- `enable` low: `ptr` and `ts` hold and no events are generated. The FIFO keeps draining to the consumer.
- `clear`: FIFO emptied, `last[*]=0`, `ptr=0`, `ts=0`, `drop_cnt=0`, first latch cleared, state becomes IDLE. Any sample in that cycle is discarded.
- `any_taint = |last[*]`, computed from registers.

## Timing
- Reset values: `ev_valid=0`, `ev_src=0`, `ev_sum=0`, `ev_prev=0`, `ev_time=0`, `drop_cnt=0`, `any_taint=0`, `first_valid=0`, `first_src=0`, `first_time=0`; state IDLE, `ptr=0`, `ts=0`.
- `enable` rising at cycle t: the first sample is taken at cycle t+1 (IDLE→SCAN transition cycle), at `ptr=0` with `ts=0`.
- Sample at cycle t with an empty FIFO: `ev_valid=1` at t+1. The FIFO is show-ahead, so the head's fields are valid while `ev_valid` is high.
- Handshake:
  - Transfer occurs on a rising edge with `ev_valid & ev_ready`.
  - While `ev_valid` is high, the fields stay stable until accepted.
  - `ev_ready` may toggle freely.
- Full scan period: N_SRC enabled cycles. A source change is reported within N_SRC cycles; changes shorter than the scan period may be missed (accepted limitation).
- `any_taint` and the first-taint outputs update one cycle after the sampling edge.
- `pos_arst` asserted mid-operation: all state clears immediately. FIFO contents are lost and `ev_valid` falls asynchronously.

## Structure
- Package `pift_mon_pkg`:
  - Event struct typedef {src, sum, prev, time}, parameterized through localparam widths.
  - FSM state enum {IDLE, SCAN}.
  - `DROP_W=16` constant.
- Sub-module `pift_evt_fifo`: synchronous show-ahead FIFO with count-based full/empty, simultaneous push/pop when full, and synchronous flush input. Scanner FSM, `last[]` array and latch logic live in the top.

## Test plan
- Reset; `enable=1` with all sums 0 for 20 cycles → `ev_valid` never rises; `any_taint=0`; `first_valid=0`.
- Source 3 set to 0x0005 from cycle 0 → exactly one event {src=3, sum=5, prev=0, time=3}; `first_valid=1`, `first_src=3`, `first_time=3`.
- `ev_ready=0`, DEPTH=8, all 8 sources change twice, 16 changes total → 8 events queued, `drop_cnt=8`; draining yields the first 8 in source order.
- FIFO full, `ev_ready=1`, new change sampled in the same cycle → `drop_cnt` unchanged and FIFO count stays 8.
- `enable` low for 5 cycles mid-scan at `ptr=5` → `ts` holds; after re-enable and the IDLE→SCAN cycle, the next sample is `ptr=5`.
- `clear` pulsed with 3 events queued → `ev_valid=0` next cycle, `drop_cnt=0`, `first_valid=0`; an unchanged nonzero source is re-reported as {prev=0}.

Source files
------------

// File: rtl/pift_mon_pkg.sv
// Shared types and constants for the taint event scanner: scan FSM states,
// the event record layout at default widths, and the drop counter width.
package pift_mon_pkg;

   localparam int DROP_W    = 16;
   localparam int DEF_N_SRC = 8;
   localparam int DEF_SUM_W = 16;
   localparam int DEF_TS_W  = 32;
   localparam int DEF_IDX_W = $clog2(DEF_N_SRC);

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } scan_state_t;

   // One change event; the FIFO carries it flattened as {src, sum, prev, ts}.
   typedef struct packed {
      logic [DEF_IDX_W-1:0] src;
      logic [DEF_SUM_W-1:0] sum;
      logic [DEF_SUM_W-1:0] prev;
      logic [DEF_TS_W-1:0]  ts;
   } ev_t;

endpackage

// File: rtl/pift_evt_fifo.sv
// Show-ahead event FIFO. Count-based full/empty, a push into a full FIFO is
// accepted when a pop happens on the same edge, synchronous flush.
module pift_evt_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 8
) (
   input  logic         pos_clk,
   input  logic         pos_arst,
   input  logic         flush,
   input  logic         push,
   input  logic [W-1:0] push_data,
   output logic         push_ok,
   input  logic         pop_ready,
   output logic         valid,
   output logic [W-1:0] head
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          full;
   logic          pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign valid   = (count != '0);
   assign pop     = valid & pop_ready;
   assign push_ok = push & (~full | pop);
   // Outputs read as zero while empty so the event fields have a defined reset value.
   assign head    = valid ? mem[rd_ptr] : '0;

   // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge pos_clk or posedge pos_arst) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (pos_arst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         if (push_ok && !pop)      count <= count + 1'b1;
         else if (pop && !push_ok) count <= count - 1'b1;
      end
   end

   // Event storage write port.
   always_ff @(posedge pos_clk) begin
      // NOTE: storage array is not reset; the occupancy count alone decides what is valid.
      if (push_ok && !flush) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/taint_event_scanner.sv
// Round-robin poller of per-source taint sums. Emits an event whenever a
// source's sum differs from the last recorded value, counts events lost to a
// full FIFO, and latches the first source/time seen tainted.
module taint_event_scanner
   import pift_mon_pkg::*;
#(
   parameter int  N_SRC = DEF_N_SRC,
   parameter int  SUM_W = DEF_SUM_W,
   parameter int  TS_W  = DEF_TS_W,
   parameter int  DEPTH = 8,
   localparam int IDX_W = $clog2(N_SRC)
) (
   input  logic                   pos_clk,
   input  logic                   pos_arst,
   input  logic                   enable,
   input  logic                   clear,
   input  logic [N_SRC*SUM_W-1:0] src_sum,
   output logic                   ev_valid,
   input  logic                   ev_ready,
   output logic [IDX_W-1:0]       ev_src,
   output logic [SUM_W-1:0]       ev_sum,
   output logic [SUM_W-1:0]       ev_prev,
   output logic [TS_W-1:0]        ev_time,
   output logic [DROP_W-1:0]      drop_cnt,
   output logic                   any_taint,
   output logic                   first_valid,
   output logic [IDX_W-1:0]       first_src,
   output logic [TS_W-1:0]        first_time
);

   localparam int EV_W = IDX_W + 2*SUM_W + TS_W;

   scan_state_t      state;
   scan_state_t      state_nx;
   logic [IDX_W-1:0] ptr;
   logic [TS_W-1:0]  ts;
   logic [SUM_W-1:0] last [N_SRC];
   logic [SUM_W-1:0] s;
   logic [SUM_W-1:0] prev;
   logic             scan_go;
   logic             push;
   logic             push_ok;
   logic [EV_W-1:0]  push_data;
   logic [EV_W-1:0]  head;

   // Next-state logic: clear forces IDLE, enable steers IDLE<->SCAN.
   always_comb begin
      // NOTE: default assignment first so no path leaves state_nx unassigned (no latch).
      state_nx = state;
      case (state)
         IDLE:    if (enable)  state_nx = SCAN;
         SCAN:    if (!enable) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      if (clear) state_nx = IDLE;
   end

   // Scan state register.
   always_ff @(posedge pos_clk or posedge pos_arst) begin
      if (pos_arst) state <= IDLE;
      else          state <= state_nx;
   end

   assign scan_go   = (state == SCAN) && enable && !clear;
   assign s         = src_sum[int'(ptr)*SUM_W +: SUM_W];
   assign prev      = last[ptr];
   assign push      = scan_go && (s != prev);
   assign push_data = {ptr, s, prev, ts};

   // Scan pointer and timestamp advance only on active scan cycles.
   always_ff @(posedge pos_clk or posedge pos_arst) begin
      if (pos_arst || clear) begin
         ptr <= '0;
         ts  <= '0;
      end else if (scan_go) begin
         ptr <= (ptr == IDX_W'(N_SRC-1)) ? '0 : ptr + 1'b1;
         ts  <= ts + 1'b1;
      end
   end

   // Recorded sums; updated even when the event itself is dropped.
   always_ff @(posedge pos_clk or posedge pos_arst) begin
      if (pos_arst || clear) begin
         for (int i = 0; i < N_SRC; i++) last[i] <= '0;
      end else if (scan_go) begin
         last[ptr] <= s;
      end
   end

   // Saturating count of events refused by the FIFO.
   always_ff @(posedge pos_clk or posedge pos_arst) begin
      if (pos_arst || clear)                        drop_cnt <= '0;
      else if (push && !push_ok && drop_cnt != '1)  drop_cnt <= drop_cnt + 1'b1;
   end

   // Sticky first-taint latch.
   always_ff @(posedge pos_clk or posedge pos_arst) begin
      if (pos_arst || clear) begin
         first_valid <= 1'b0;
         first_src   <= '0;
         first_time  <= '0;
      end else if (scan_go && s != '0 && !first_valid) begin
         first_valid <= 1'b1;
         first_src   <= ptr;
         first_time  <= ts;
      end
   end

   // Any recorded sum nonzero.
   always_comb begin
      any_taint = 1'b0;
      for (int i = 0; i < N_SRC; i++) any_taint = any_taint | (|last[i]);
   end

   pift_evt_fifo #(
      .W     (EV_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .pos_clk   (pos_clk),
      .pos_arst  (pos_arst),
      .flush     (clear),
      .push      (push),
      .push_data (push_data),
      .push_ok   (push_ok),
      .pop_ready (ev_ready),
      .valid     (ev_valid),
      .head      (head)
   );

   assign {ev_src, ev_sum, ev_prev, ev_time} = head;

endmodule

// File: tb/tb_taint_event_scanner.sv
// Self-checking bench for taint_event_scanner: table-driven change vectors on
// a running scan plus hand-written sequences for FIFO-full, pause, clear and
// asynchronous reset. Expected events go into a scoreboard queue.
module tb_taint_event_scanner;
   import pift_mon_pkg::*;

   localparam int N = 8;
   localparam int SW = 16;

   logic            pos_clk = 1'b0;
   logic            pos_arst;
   logic            enable;
   logic            clear;
   logic [N*SW-1:0] src_sum;
   logic            ev_valid;
   logic            ev_ready;
   logic [2:0]      ev_src;
   logic [15:0]     ev_sum;
   logic [15:0]     ev_prev;
   logic [31:0]     ev_time;
   logic [15:0]     drop_cnt;
   logic            any_taint;
   logic            first_valid;
   logic [2:0]      first_src;
   logic [31:0]     first_time;

   logic [SW-1:0]   srcs [N];
   int              n_checks = 0;
   int              n_fail   = 0;
   ev_t             sb [$];
   logic            hold_vld = 1'b0;
   ev_t             hold_val;

   typedef struct {
      int          src;
      logic [15:0] val;
      logic [15:0] prev;
      logic [31:0] t;
   } vec_t;
   vec_t tbl [8];

   taint_event_scanner dut (
      .pos_clk     (pos_clk),
      .pos_arst    (pos_arst),
      .enable      (enable),
      .clear       (clear),
      .src_sum     (src_sum),
      .ev_valid    (ev_valid),
      .ev_ready    (ev_ready),
      .ev_src      (ev_src),
      .ev_sum      (ev_sum),
      .ev_prev     (ev_prev),
      .ev_time     (ev_time),
      .drop_cnt    (drop_cnt),
      .any_taint   (any_taint),
      .first_valid (first_valid),
      .first_src   (first_src),
      .first_time  (first_time)
   );

   always #5 pos_clk = ~pos_clk;

   always_comb begin
      src_sum = '0;
      for (int i = 0; i < N; i++) src_sum[i*SW +: SW] = srcs[i];
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic ev_t mk_ev(input int src, input logic [15:0] sum,
                                 input logic [15:0] prev, input logic [31:0] t);
      ev_t e;
      e.src  = 3'(src);
      e.sum  = sum;
      e.prev = prev;
      e.ts   = t;
      return e;
   endfunction

   task automatic step(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge pos_clk);
         #1;
      end
   endtask

   // Clear edge, then the IDLE->SCAN edge; returns just before the ts=0 sample edge.
   task automatic clear_and_start();
      clear  = 1'b1;
      enable = 1'b1;
      step();
      clear = 1'b0;
      step();
   endtask

   // Consumer side: compare every transfer against the scoreboard and check
   // that a stalled head stays stable.
   always @(negedge pos_clk) begin
      ev_t got;
      got = {ev_src, ev_sum, ev_prev, ev_time};
      if (pos_arst) begin
         hold_vld = 1'b0;
      end else begin
         if (hold_vld && ev_valid) check("hold_stable", got, hold_val);
         if (ev_valid && ev_ready) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL event_unexpected: got 0x%0h expected none", got);
            end else begin
               check("event", got, sb.pop_front());
            end
         end
         hold_vld = ev_valid && !ev_ready;
         hold_val = got;
      end
   end

   initial begin
      int vcount;

      tbl[0] = '{src: 3, val: 16'h0005, prev: 16'h0000, t: 32'd3};
      tbl[1] = '{src: 3, val: 16'h0007, prev: 16'h0005, t: 32'd11};
      tbl[2] = '{src: 0, val: 16'hFFFF, prev: 16'h0000, t: 32'd16};
      tbl[3] = '{src: 7, val: 16'h1234, prev: 16'h0000, t: 32'd31};
      tbl[4] = '{src: 3, val: 16'h0000, prev: 16'h0007, t: 32'd35};
      tbl[5] = '{src: 0, val: 16'h0000, prev: 16'hFFFF, t: 32'd40};
      tbl[6] = '{src: 7, val: 16'h0000, prev: 16'h1234, t: 32'd55};
      tbl[7] = '{src: 5, val: 16'h0001, prev: 16'h0000, t: 32'd61};

      pos_arst = 1'b1;
      enable   = 1'b0;
      clear    = 1'b0;
      ev_ready = 1'b1;
      for (int i = 0; i < N; i++) srcs[i] = '0;
      #1;
      check("rst_ev_valid", ev_valid, 0);
      check("rst_ev_fields", {ev_src, ev_sum, ev_prev, ev_time}, 0);
      check("rst_drop_cnt", drop_cnt, 0);
      check("rst_any_taint", any_taint, 0);
      check("rst_first", {first_valid, first_src, first_time}, 0);
      step(2);
      pos_arst = 1'b0;

      // All sums zero: scanning must produce nothing.
      enable = 1'b1;
      vcount = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (ev_valid) vcount++;
      end
      check("zero_no_events", vcount, 0);
      check("zero_any_taint", any_taint, 0);
      check("zero_first_valid", first_valid, 0);

      // Table-driven changes, one per scan period; row i sampled at ts = 8*i + src.
      clear_and_start();
      for (int i = 0; i < 8; i++) begin
         srcs[tbl[i].src] = tbl[i].val;
         sb.push_back(mk_ev(tbl[i].src, tbl[i].val, tbl[i].prev, tbl[i].t));
         step(8);
      end
      check("tbl_first_valid", first_valid, 1);
      check("tbl_first_src", first_src, 3);
      check("tbl_first_time", first_time, 3);
      check("tbl_any_taint_set", any_taint, 1);
      srcs[5] = '0;
      sb.push_back(mk_ev(5, 16'h0000, 16'h0001, 32'd69));
      step(8);
      check("tbl_any_taint_clr", any_taint, 0);
      check("tbl_sb_empty", sb.size(), 0);

      // Overflow: 16 changes with the consumer stalled.
      clear_and_start();
      ev_ready = 1'b0;
      for (int i = 0; i < N; i++) begin
         srcs[i] = 16'(i + 1);
         sb.push_back(mk_ev(i, 16'(i + 1), 16'h0000, 32'(i)));
      end
      step(8);
      for (int i = 0; i < N; i++) srcs[i] = 16'h0100 + 16'(i);
      step(8);
      check("ovf_drop_cnt", drop_cnt, 8);
      check("ovf_valid", ev_valid, 1);
      check("ovf_first", {first_valid, first_src, first_time}, {1'b1, 3'd0, 32'd0});

      // Full FIFO with a pop on the same edge as a new push: nothing dropped.
      srcs[0]  = 16'h0200;
      ev_ready = 1'b1;
      sb.push_back(mk_ev(0, 16'h0200, 16'h0100, 32'd16));
      step();
      ev_ready = 1'b0;
      check("fullpop_drop_cnt", drop_cnt, 8);
      ev_ready = 1'b1;
      step(10);
      check("drain_sb_empty", sb.size(), 0);
      check("drain_valid_low", ev_valid, 0);
      check("drain_drop_cnt", drop_cnt, 8);

      // Clear with three events pending; then unchanged sources re-report with prev=0.
      ev_ready = 1'b0;
      srcs[1]  = 16'h0AAA;
      srcs[2]  = 16'h0BBB;
      srcs[3]  = 16'h0CCC;
      step(9);
      check("preclr_valid", ev_valid, 1);
      clear = 1'b1;
      step();
      clear = 1'b0;
      check("clr_valid", ev_valid, 0);
      check("clr_drop_cnt", drop_cnt, 0);
      check("clr_first_valid", first_valid, 0);
      check("clr_any_taint", any_taint, 0);
      ev_ready = 1'b1;
      for (int i = 0; i < N; i++) sb.push_back(mk_ev(i, srcs[i], 16'h0000, 32'(i)));
      step(13);
      check("rereport_sb_empty", sb.size(), 0);
      check("rereport_first", {first_valid, first_src, first_time}, {1'b1, 3'd0, 32'd0});

      // Pause with ptr=5: timestamp holds and scanning resumes at source 5.
      for (int i = 0; i < N; i++) srcs[i] = '0;
      clear_and_start();
      step(5);
      enable = 1'b0;
      step();
      srcs[5] = 16'h0055;
      srcs[4] = 16'h0044;
      step(4);
      check("pause_no_event", ev_valid, 0);
      enable = 1'b1;
      sb.push_back(mk_ev(5, 16'h0055, 16'h0000, 32'd5));
      sb.push_back(mk_ev(4, 16'h0044, 16'h0000, 32'd12));
      step(14);
      check("pause_sb_empty", sb.size(), 0);

      // Asynchronous reset with an event pending.
      ev_ready = 1'b0;
      srcs[0]  = 16'h0011;
      step(9);
      check("prerst_valid", ev_valid, 1);
      #2;
      pos_arst = 1'b1;
      #1;
      check("arst_valid", ev_valid, 0);
      check("arst_fields", {ev_src, ev_sum, ev_prev, ev_time}, 0);
      check("arst_state", {drop_cnt, any_taint, first_valid, first_src, first_time}, 0);
      step();
      pos_arst = 1'b0;
      step(2);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
